instruction_fetch_unit: RTL and testbench

Fetch stage sitting directly upstream of InstructionMemory and downstream-feeding the decode stage. Holds the program counter and drives the memory read port (rd/address) to issue sequential fetches. Captures the combinational read_data into a small prefetch buffer and presents instructions to decode over a valid/ready handshake. Supports control-flow redirect (flush) and halt.

---
 rtl/instruction_fetch_unit_if.sv | 51 +++++
 rtl/instruction_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect/halt control
// and the decode-side valid/ready instruction stream.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned INSTR_WIDTH = 24
);
    logic                   imem_rd;
    logic                   imem_wn;
    logic [ADDR_WIDTH-1:0]  imem_address;
    logic [INSTR_WIDTH-1:0] imem_read_data;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   halt;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   busy;

    // Fetch unit side.
    modport master (
        output imem_rd,
        output imem_wn,
        output imem_address,
        input  imem_read_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output busy
    );

    // Memory / decode / control side.
    modport slave (
        input  imem_rd,
        input  imem_wn,
        input  imem_address,
        output imem_read_data,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  busy
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues sequential reads to a
// combinational instruction memory, buffers {instr, pc} pairs in a small FIFO
// and hands them to decode over valid/ready. Supports redirect and halt.
module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           INSTR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 16'h0000,
    parameter int unsigned           BUF_DEPTH   = 2
) (
    input logic                      clk,
    input logic                      rst,
    instruction_fetch_unit_if.master bus
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHalted
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [INSTR_WIDTH-1:0] buf_data_q [BUF_DEPTH];
    logic [INSTR_WIDTH-1:0] buf_data_d [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]  buf_pc_q   [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]  buf_pc_d   [BUF_DEPTH];

    logic issue;
    logic head_valid;
    logic pop;
    logic flush;

    // Handshake decode; halt also blocks issue in the cycle it is first seen,
    // and a full buffer takes no credit for a same-cycle pop.
    always_comb begin
        issue      = !rst && (state_q == StFetch) && (count_q < DepthCnt) &&
                     !bus.redirect_valid && !bus.halt;
        head_valid = !rst && (count_q != '0);
        pop        = head_valid && bus.instr_ready;
        flush      = !rst && bus.redirect_valid && (state_q != StIdle);
    end

    assign bus.imem_rd      = issue;
    assign bus.imem_wn      = 1'b0;
    assign bus.imem_address = pc_q;
    assign bus.instr_valid  = head_valid;
    assign bus.instr_data   = buf_data_q[rd_ptr_q];
    assign bus.instr_pc     = buf_pc_q[rd_ptr_q];
    assign bus.busy         = !rst && (state_q == StFetch);

    // Next-state logic for the FSM, PC and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        unique case (state_q)
            StIdle:   state_d = bus.halt ? StHalted : StFetch;
            StFetch:  if (bus.halt) state_d = StHalted;
            StHalted: if (!bus.halt) state_d = StFetch;
            default:  state_d = StIdle;
        endcase

        if (flush) begin
            // Redirect drops everything in flight, including a same-cycle pop.
            pc_d     = bus.redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d     = pc_q + ADDR_WIDTH'(1);
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({issue, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer write port: capture memory data and its address on issue.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        if (issue) begin
            buf_data_d[wr_ptr_q] = bus.imem_read_data;
            buf_pc_d[wr_ptr_q]   = pc_q;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Buffer storage; contents are only meaningful under count_q.
    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
        buf_pc_q   <= buf_pc_d;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run scored against a queue-based model of the fetch stream.
module tb_instruction_fetch_unit;

    logic clk;
    logic rst;
    logic [23:0] mem [65536];
    int n_tests;
    int n_fail;

    instruction_fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(24)) bus ();

    instruction_fetch_unit #(
        .ADDR_WIDTH (16),
        .INSTR_WIDTH(24),
        .RESET_PC   (16'h0000),
        .BUF_DEPTH  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.imem_read_data = mem[bus.imem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Hold reset for two edges, release it; returns in the IDLE cycle.
    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.halt = 1'b0;
        bus.instr_ready = rdy;
        step();
        step();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.halt = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        settle();
        n_tests++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd: got %b want 0", bus.imem_rd); end
        n_tests++; if (bus.imem_wn !== 1'b0) begin n_fail++; $display("FAIL rst_wn: got %b want 0", bus.imem_wn); end
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
        settle();
        n_tests++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL idle_rd: got %b want 0", bus.imem_rd); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
        step();
        settle();
        n_tests++; if (bus.imem_rd !== 1'b1) begin n_fail++; $display("FAIL first_rd: got %b want 1", bus.imem_rd); end
        n_tests++; if (bus.imem_address !== 16'h0000) begin n_fail++; $display("FAIL first_addr: got %h want 0000", bus.imem_address); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b want 1", bus.busy); end
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid: got %b want 0", bus.instr_valid); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        step(); settle();
        for (int k = 0; k < 8; k++) begin
            step(); settle();
            n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.instr_valid); end
            n_tests++; if (bus.instr_data !== 24'(k + 1)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", k, bus.instr_data, 24'(k + 1)); end
            n_tests++; if (bus.instr_pc !== 16'(k)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.instr_pc, 16'(k)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        step(); settle();
        step(); settle();
        step(); settle();
        n_tests++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_full_rd: got %b want 0", bus.imem_rd); end
        n_tests++; if (bus.imem_address !== 16'h0002) begin n_fail++; $display("FAIL bp_full_pc: got %h want 0002", bus.imem_address); end
        step(); settle();
        n_tests++; if (bus.imem_address !== 16'h0002) begin n_fail++; $display("FAIL bp_hold_pc: got %h want 0002", bus.imem_address); end
        bus.instr_ready = 1'b1;
        settle();
        n_tests++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_no_credit: got %b want 0", bus.imem_rd); end
        for (int j = 0; j < 6; j++) begin
            n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", j, bus.instr_valid); end
            n_tests++; if (bus.instr_data !== 24'(j + 1)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", j, bus.instr_data, 24'(j + 1)); end
            n_tests++; if (bus.instr_pc !== 16'(j)) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h want %h", j, bus.instr_pc, 16'(j)); end
            step(); settle();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        step(); settle();
        step(); settle();
        step(); settle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0005;
        settle();
        n_tests++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL redir_rd: got %b want 0", bus.imem_rd); end
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b1;
        settle();
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b want 0", bus.instr_valid); end
        n_tests++; if (bus.imem_rd !== 1'b1) begin n_fail++; $display("FAIL redir_issue: got %b want 1", bus.imem_rd); end
        n_tests++; if (bus.imem_address !== 16'h0005) begin n_fail++; $display("FAIL redir_addr: got %h want 0005", bus.imem_address); end
        step(); settle();
        n_tests++; if (bus.instr_data !== 24'd6) begin n_fail++; $display("FAIL redir_data: got %h want 000006", bus.instr_data); end
        n_tests++; if (bus.instr_pc !== 16'h0005) begin n_fail++; $display("FAIL redir_pc: got %h want 0005", bus.instr_pc); end
    endtask

    task automatic test_halt();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(); settle();
        end
        bus.halt = 1'b1;
        settle();
        n_tests++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_rd: got %b want 0", bus.imem_rd); end
        n_tests++; if (bus.imem_address !== 16'h0003) begin n_fail++; $display("FAIL halt_addr: got %h want 0003", bus.imem_address); end
        n_tests++; if (bus.instr_pc !== 16'h0002) begin n_fail++; $display("FAIL halt_drain_pc: got %h want 0002", bus.instr_pc); end
        step(); settle();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL halted_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL halted_drained: got %b want 0", bus.instr_valid); end
        step();
        bus.halt = 1'b0;
        settle();
        n_tests++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL unhalt_rd: got %b want 0", bus.imem_rd); end
        n_tests++; if (bus.imem_address !== 16'h0003) begin n_fail++; $display("FAIL halted_pc: got %h want 0003", bus.imem_address); end
        step(); settle();
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL resume_busy: got %b want 1", bus.busy); end
        n_tests++; if (bus.imem_rd !== 1'b1) begin n_fail++; $display("FAIL resume_rd: got %b want 1", bus.imem_rd); end
        step(); settle();
        n_tests++; if (bus.instr_pc !== 16'h0003 || bus.instr_data !== 24'd4) begin n_fail++; $display("FAIL resume_head: got %h/%h want 0003/000004", bus.instr_pc, bus.instr_data); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFF;
        exp_pc[1] = 16'h0000;
        exp_pc[2] = 16'h0001;
        do_reset(1'b1);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        settle();
        step();
        bus.redirect_valid = 1'b0;
        settle();
        n_tests++; if (bus.imem_address !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr0: got %h want ffff", bus.imem_address); end
        step(); settle();
        n_tests++; if (bus.imem_address !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr1: got %h want 0000", bus.imem_address); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (bus.instr_pc !== exp_pc[i] || bus.instr_data !== mem[exp_pc[i]]) begin n_fail++; $display("FAIL wrap_head[%0d]: got %h/%h want %h/%h", i, bus.instr_pc, bus.instr_data, exp_pc[i], mem[exp_pc[i]]); end
            step(); settle();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            step(); settle();
        end
        rst = 1'b1;
        settle();
        n_tests++; if (bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got v=%b rd=%b want 0/0", bus.instr_valid, bus.imem_rd); end
        step();
        rst = 1'b0;
        settle();
        n_tests++; if (bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got v=%b rd=%b want 0/0", bus.instr_valid, bus.imem_rd); end
        step(); settle();
        n_tests++; if (bus.imem_rd !== 1'b1 || bus.imem_address !== 16'h0000) begin n_fail++; $display("FAIL midrst_refetch: got rd=%b addr=%h want 1/0000", bus.imem_rd, bus.imem_address); end
    endtask

    // Model: a queue of fetched addresses, a fetch PC, and whether fetching is
    // enabled this cycle (halt was low on the previous edge and the unit is
    // past its one idle cycle).
    task automatic test_random();
        logic [15:0] q [$];
        logic [15:0] fpc;
        logic idle;
        logic halt_prev;
        logic exp_rd;
        logic exp_valid;
        logic exp_busy;
        for (int a = 0; a < 65536; a++) mem[a] = 24'($urandom);
        do_reset(1'b1);
        idle = 1'b1;
        halt_prev = 1'b0;
        fpc = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            exp_rd = !rst && !idle && !halt_prev && !bus.halt && (q.size() < 2) && !bus.redirect_valid;
            exp_valid = !rst && (q.size() > 0);
            exp_busy = !rst && !idle && !halt_prev;
            n_tests++; if (bus.imem_rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rd@%0d: got %b want %b", c, bus.imem_rd, exp_rd); end
            n_tests++; if (bus.instr_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.instr_valid, exp_valid); end
            n_tests++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", c, bus.busy, exp_busy); end
            n_tests++; if (bus.imem_wn !== 1'b0) begin n_fail++; $display("FAIL rnd_wn@%0d: got %b want 0", c, bus.imem_wn); end
            if (!rst) begin
                n_tests++; if (bus.imem_address !== fpc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", c, bus.imem_address, fpc); end
            end
            if (exp_valid) begin
                n_tests++; if (bus.instr_pc !== q[0] || bus.instr_data !== mem[q[0]]) begin n_fail++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", c, bus.instr_pc, bus.instr_data, q[0], mem[q[0]]); end
            end
            if (rst) begin
                idle = 1'b1;
                q.delete();
                fpc = 16'h0000;
                halt_prev = 1'b0;
            end else if (idle) begin
                idle = 1'b0;
                halt_prev = bus.halt;
            end else begin
                if (bus.redirect_valid) begin
                    q.delete();
                    fpc = bus.redirect_pc;
                end else begin
                    if (exp_valid && bus.instr_ready) void'(q.pop_front());
                    if (exp_rd) begin
                        q.push_back(fpc);
                        fpc = fpc + 16'h0001;
                    end
                end
                halt_prev = bus.halt;
            end
            step();
            rst = ($urandom % 256) == 0;
            bus.instr_ready = ($urandom % 4) != 0;
            if (($urandom % 8) == 0) bus.halt = !bus.halt;
            bus.redirect_valid = ($urandom % 16) == 0;
            bus.redirect_pc = (($urandom % 3) == 0) ? 16'(16'hFFFE + 16'($urandom % 2)) : 16'($urandom);
            settle();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 24'(a + 1);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
